rmii_rx_deser: RTL and testbench

RMII receive front end for the MAC. It consumes the 50 MHz RMII receive interface (crs_dv, rxd[1:0], rx_er) and drops the preamble/SFD. It assembles dibits into bytes, LSB first, and emits a byte stream with start-of-frame and end-of-frame markers. At end of frame it reports status: FCS check, length limits, alignment and PHY error.

---
 rtl/rmii_rx_deser.sv | 152 +++++++++++++++
 tb/tb_rmii_rx_deser.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rmii_rx_deser.sv
// rmii_rx_deser: RMII receive front end: strips preamble/SFD, packs dibits into bytes and reports frame status at end of frame
module rmii_rx_deser #(
  parameter int MIN_PRE = 8,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crs_dv,
  input  logic       rx_er,
  input  logic [1:0] rxd,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_sof,
  output logic       m_eof,
  output logic       m_crc_ok,
  output logic       m_err
);
  typedef enum logic [1:0] {IDLE, PRE, RECV, DROP} state_t;
  localparam logic [3:0]  PRE_MIN = 4'(MIN_PRE);
  localparam logic [10:0] LEN_MIN = 11'(MIN_LEN);
  localparam logic [10:0] LEN_MAX = 11'(MAX_LEN);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  state_t state_q, state_d;
  logic gap_q, gap_d, er_q, er_d, sof_q, sof_d;
  logic [3:0] pre_q, pre_d;
  logic [1:0] dcnt_q, dcnt_d;
  logic [7:0] sh_q, sh_d, hold_q, hold_d, full;
  logic [10:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0] dat_q, dat_d;
  logic vld_q, vld_d, osof_q, osof_d, eof_q, eof_d, ok_q, ok_d, err_q, err_d;
  logic eoc, crc_good;
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  assign full = {rxd, sh_q[7:2]};
  assign eoc = !crs_dv && gap_q;
  assign crc_good = crc_q == RESIDUE;
  always_comb begin
    state_d = state_q;
    gap_d = !crs_dv && state_q != IDLE;
    er_d = er_q;
    sof_d = sof_q;
    pre_d = pre_q;
    dcnt_d = dcnt_q;
    sh_d = sh_q;
    hold_d = hold_q;
    len_d = len_q;
    crc_d = crc_q;
    dat_d = dat_q;
    vld_d = 1'b0;
    osof_d = 1'b0;
    eof_d = 1'b0;
    ok_d = 1'b0;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      if (crs_dv) begin
        state_d = rxd == 2'b01 ? PRE : DROP;
        pre_d = 4'd1;
      end
    end else if (eoc) begin
      state_d = IDLE;
      // the held byte is the true last byte; a zero-byte frame has nothing held
      if (state_q == RECV && len_q != 11'd0) begin
        vld_d = 1'b1;
        dat_d = hold_q;
        osof_d = sof_q;
        eof_d = 1'b1;
        ok_d = crc_good;
        err_d = er_q || dcnt_q != 2'd0 || len_q < LEN_MIN || len_q > LEN_MAX || !crc_good;
      end
    end else if (crs_dv) begin
      if (state_q == PRE) begin
        if (rxd == 2'b01) pre_d = pre_q == 4'd15 ? pre_q : pre_q + 4'd1;
        else if (rxd == 2'b11 && pre_q >= PRE_MIN) begin
          state_d = RECV;
          dcnt_d = 2'd0;
          sh_d = 8'd0;
          len_d = 11'd0;
          crc_d = 32'hFFFFFFFF;
          er_d = 1'b0;
          sof_d = 1'b1;
        end else state_d = DROP;
      end else if (state_q == RECV) begin
        er_d = er_q || rx_er;
        sh_d = full;
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == 2'd3) begin
          len_d = len_q == 11'h7FF ? len_q : len_q + 11'd1;
          crc_d = crc_step(crc_q, full);
          // past MAX_LEN the last in-range byte stays held for the end-of-frame marker
          if (len_q < LEN_MAX) begin
            hold_d = full;
            if (len_q != 11'd0) begin
              vld_d = 1'b1;
              dat_d = hold_q;
              osof_d = sof_q;
              sof_d = 1'b0;
            end
          end
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q <= 1'b0;
      er_q <= 1'b0;
      sof_q <= 1'b0;
      pre_q <= 4'd0;
      dcnt_q <= 2'd0;
      sh_q <= 8'd0;
      hold_q <= 8'd0;
      len_q <= 11'd0;
      crc_q <= 32'd0;
      dat_q <= 8'd0;
      vld_q <= 1'b0;
      osof_q <= 1'b0;
      eof_q <= 1'b0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      er_q <= er_d;
      sof_q <= sof_d;
      pre_q <= pre_d;
      dcnt_q <= dcnt_d;
      sh_q <= sh_d;
      hold_q <= hold_d;
      len_q <= len_d;
      crc_q <= crc_d;
      dat_q <= dat_d;
      vld_q <= vld_d;
      osof_q <= osof_d;
      eof_q <= eof_d;
      ok_q <= ok_d;
      err_q <= err_d;
    end
  end
  assign m_data = dat_q;
  assign m_valid = vld_q;
  assign m_sof = osof_q;
  assign m_eof = eof_q;
  assign m_crc_ok = ok_q;
  assign m_err = err_q;
endmodule

// File: tb/tb_rmii_rx_deser.sv
// tb_rmii_rx_deser: frame-level table, corner sequences and random frames against a byte-stream reference model
module tb_rmii_rx_deser;
  localparam int MIN_PRE = 8;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1522;
  logic clk = 1'b0, rst, crs_dv, rx_er;
  logic [1:0] rxd;
  logic [7:0] m_data;
  logic m_valid, m_sof, m_eof, m_crc_ok, m_err;
  typedef struct {logic [7:0] d; logic s, e, ok, er;} out_t;
  typedef struct {int npre, npay; bit fcs; int corrupt, tail, gap, er_byte; bit bad_pre; int n, ok, err;} vec_t;
  out_t got[$];
  logic [7:0] exp_q[$];
  bit exp_eof, exp_ok, exp_err;
  int nchk = 0, npass = 0, cyc = 0, last_v = -100, viol = 0;
  vec_t tv[15];
  rmii_rx_deser #(.MIN_PRE(MIN_PRE), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .crs_dv(crs_dv), .rx_er(rx_er), .rxd(rxd),
    .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_eof(m_eof),
    .m_crc_ok(m_crc_ok), .m_err(m_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    out_t o;
    #1;
    cyc++;
    if (m_valid) begin
      o.d = m_data; o.s = m_sof; o.e = m_eof; o.ok = m_crc_ok; o.er = m_err;
      got.push_back(o);
      if (cyc - last_v < 2) viol++;
      last_v = cyc;
    end
  end
  initial begin
    #3ms;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic logic [31:0] crc32(input logic [7:0] f[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (f[i]) begin
      c = c ^ {24'd0, f[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return c;
  endfunction
  task automatic send(input int npre, input int npay, input bit fcs, input int corrupt, input int tail,
                      input int gap, input int er_byte, input bit bad_pre, input int rst_at, input bit rnd);
    logic [7:0] f[$];
    logic [1:0] d[$];
    logic [31:0] c;
    logic [7:0] b;
    int s, nb, keep;
    bit acc;
    for (int i = 0; i < npay; i++) f.push_back(rnd ? 8'($urandom) : 8'(i));
    if (fcs) begin
      c = ~crc32(f);
      for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
    end
    if (corrupt >= 0) f[corrupt] = f[corrupt] ^ 8'hF5;
    for (int i = 0; i < npre; i++) d.push_back(bad_pre && i == npre / 2 ? 2'b10 : 2'b01);
    d.push_back(2'b11);
    s = d.size();
    foreach (f[i]) begin
      b = f[i];
      for (int k = 0; k < 4; k++) d.push_back(b[2*k +: 2]);
    end
    for (int i = 0; i < tail; i++) d.push_back(2'($urandom));
    nb = f.size();
    acc = !bad_pre && npre >= MIN_PRE;
    keep = !acc ? 0 : rst_at >= 0 ? rst_at - 1 : nb < MAX_LEN ? nb : MAX_LEN;
    exp_q = {};
    for (int i = 0; i < keep; i++) exp_q.push_back(f[i]);
    exp_eof = acc && rst_at < 0 && nb > 0;
    exp_ok = fcs && corrupt < 0;
    exp_err = !exp_ok || (er_byte >= 0 && er_byte < nb) || tail != 0 || nb < MIN_LEN || nb > MAX_LEN;
    got = {};
    foreach (d[j]) begin
      if (j > 0 && ((gap > 0 && j > s && (j - s) % gap == 0) || (gap < 0 && $urandom_range(5) == 0))) begin
        @(negedge clk);
        crs_dv = 1'b0; rxd = 2'($urandom); rx_er = 1'b0;
      end
      @(negedge clk);
      if (rst_at >= 0 && j == s + 4 * rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_out", int'({m_valid, m_sof, m_eof, m_crc_ok, m_err, m_data}), 0);
      end
      if (rst_at >= 0 && j == s + 4 * rst_at + 8) rst = 1'b0;
      crs_dv = 1'b1; rxd = d[j]; rx_er = er_byte >= 0 && j == s + 4 * er_byte;
    end
    repeat (2) begin
      @(negedge clk);
      crs_dv = 1'b0; rx_er = 1'b0;
    end
    repeat (6) @(negedge clk);
  endtask
  task automatic check_frame(input int n, input int ok, input int err);
    int bad, si, ei;
    chk("count", got.size(), n);
    bad = -1;
    foreach (exp_q[i]) if (bad < 0 && (i >= got.size() || got[i].d != exp_q[i])) bad = i;
    if (bad < 0 && got.size() > exp_q.size()) bad = exp_q.size();
    chk("data_first_bad_idx", bad, -1);
    si = -1; ei = -1;
    foreach (got[i]) begin
      if (got[i].s && si < 0) si = i;
      if (got[i].e && ei < 0) ei = i;
    end
    chk("sof_idx", si, n > 0 ? 0 : -1);
    chk("eof_idx", ei, exp_eof ? n - 1 : -1);
    if (exp_eof && ei >= 0) begin
      chk("crc_ok", int'(got[ei].ok), ok);
      chk("err", int'(got[ei].er), err);
    end
  endtask
  initial begin
    int npay, fs, npre, corrupt, tail, gap, er;
    bit fcs, bad;
    tv[0]  = '{31, 60, 1, -1, 0, 0, -1, 0, 64, 1, 0};
    tv[1]  = '{31, 60, 1, 10, 0, 0, -1, 0, 64, 0, 1};
    tv[2]  = '{31, 36, 1, -1, 0, 0, -1, 0, 40, 1, 1};
    tv[3]  = '{31, 60, 1, -1, 2, 0, -1, 0, 64, 1, 1};
    tv[4]  = '{31, 60, 1, -1, 0, 8, -1, 0, 64, 1, 0};
    tv[5]  = '{31, 60, 1, -1, 0, 0, 20, 0, 64, 1, 1};
    tv[6]  = '{4, 60, 1, -1, 0, 0, -1, 0, 0, 0, 0};
    tv[7]  = '{31, 60, 1, -1, 0, 0, -1, 1, 0, 0, 0};
    tv[8]  = '{31, 60, 1, -1, 0, 0, -1, 0, 64, 1, 0};
    tv[9]  = '{31, 1596, 1, -1, 0, 0, -1, 0, 1522, 1, 1};
    tv[10] = '{31, 1, 0, -1, 0, 0, -1, 0, 1, 0, 1};
    tv[11] = '{31, 0, 0, -1, 0, 0, -1, 0, 0, 0, 0};
    tv[12] = '{8, 60, 1, -1, 0, 0, -1, 0, 64, 1, 0};
    tv[13] = '{7, 60, 1, -1, 0, 0, -1, 0, 0, 0, 0};
    tv[14] = '{31, 1518, 1, -1, 0, 0, -1, 0, 1522, 1, 0};
    rst = 1'b1; crs_dv = 1'b0; rx_er = 1'b0; rxd = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_out", int'({m_valid, m_sof, m_eof, m_crc_ok, m_err, m_data}), 0);
    rst = 1'b0;
    foreach (tv[i]) begin
      send(tv[i].npre, tv[i].npay, tv[i].fcs, tv[i].corrupt, tv[i].tail, tv[i].gap, tv[i].er_byte, tv[i].bad_pre, -1, 1'b0);
      check_frame(tv[i].n, tv[i].ok, tv[i].err);
    end
    send(31, 60, 1, -1, 0, 0, -1, 0, 30, 1'b0);
    check_frame(29, 0, 0);
    send(31, 60, 1, -1, 0, 0, -1, 0, -1, 1'b0);
    check_frame(64, 1, 0);
    for (int r = 0; r < 16; r++) begin
      npre = $urandom_range(5, 31);
      npay = $urandom_range(0, 80);
      fcs = $urandom_range(3) != 0;
      fs = npay + (fcs ? 4 : 0);
      corrupt = (fs > 0 && $urandom_range(3) == 0) ? $urandom_range(0, fs - 1) : -1;
      tail = $urandom_range(2) == 0 ? $urandom_range(1, 3) : 0;
      gap = $urandom_range(1) == 0 ? -1 : 0;
      er = (npay > 0 && $urandom_range(4) == 0) ? $urandom_range(0, npay - 1) : -1;
      bad = $urandom_range(7) == 0;
      send(npre, npay, fcs, corrupt, tail, gap, er, bad, -1, 1'b1);
      check_frame(exp_q.size(), int'(exp_ok), int'(exp_err));
    end
    chk("valid_back_to_back", viol, 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
